load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory operation from execute, performs a single
// word-aligned memory transaction with byte enables, and returns an extended
// load result or a store-complete strobe.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_ready       operation handshake from execute (ready only in IDLE)
//   alucode, addr,
//   store_data, rd           operation code, byte address, store value, load dest
//   mem_req, mem_we,
//   mem_addr, mem_be,
//   mem_wdata                memory request, held until mem_ack
//   mem_ack, mem_rdata       memory completion and read data
//   wb_valid, wb_rd, wb_data load writeback strobe and held result
//   st_done                  store-complete strobe
//   misalign                 misaligned-access strobe
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        misalign
);

    // Operation codes, matching the values in define.vh.
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [5:0]  r_alucode;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [4:0]  r_rd;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_misalign;

    logic        w_in_is_mem;
    logic        w_in_misalign;
    logic        w_accept;
    logic        w_is_load;
    logic        w_is_byte;
    logic        w_is_half;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // Decode of the incoming operation.
    always_comb begin
        w_in_is_mem   = 1'b0;
        w_in_misalign = 1'b0;
        case (alucode)
            ALU_LB, ALU_LBU, ALU_SB: w_in_is_mem = 1'b1;
            ALU_LH, ALU_LHU, ALU_SH: begin
                w_in_is_mem   = 1'b1;
                w_in_misalign = addr[0];
            end
            ALU_LW, ALU_SW: begin
                w_in_is_mem   = 1'b1;
                w_in_misalign = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    assign w_accept = (r_state == StIdle) && in_valid && w_in_is_mem;

    // Decode of the latched operation.
    always_comb begin
        w_is_load = 1'b0;
        w_is_byte = 1'b0;
        w_is_half = 1'b0;
        case (r_alucode)
            ALU_LB, ALU_LBU: begin w_is_load = 1'b1; w_is_byte = 1'b1; end
            ALU_LH, ALU_LHU: begin w_is_load = 1'b1; w_is_half = 1'b1; end
            ALU_LW:          w_is_load = 1'b1;
            ALU_SB:          w_is_byte = 1'b1;
            ALU_SH:          w_is_half = 1'b1;
            default: ;
        endcase
    end

    // Lane selection and extension of the returned read data.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_alucode)
            ALU_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            ALU_LBU: w_load_data = {24'd0, w_byte};
            ALU_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            ALU_LHU: w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_accept && !w_in_misalign) w_state_next = StAccess;
            StAccess: if (mem_ack) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_alucode    <= 6'd0;
            r_addr       <= 32'd0;
            r_store_data <= 32'd0;
            r_rd         <= 5'd0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'd0;
            r_misalign   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_misalign <= w_accept && w_in_misalign;
            if (w_accept) begin
                r_alucode    <= alucode;
                r_addr       <= addr;
                r_store_data <= store_data;
                r_rd         <= rd;
            end
            if ((r_state == StAccess) && mem_ack && w_is_load) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

    // Request fields come straight from the latched operation, so they are
    // stable for the whole ACCESS phase; reset clears the latches to zero.
    always_comb begin
        if (w_is_byte) begin
            mem_be    = 4'b0001 << r_addr[1:0];
            mem_wdata = {4{r_store_data[7:0]}};
        end else if (w_is_half) begin
            mem_be    = 4'b0011 << {r_addr[1], 1'b0};
            mem_wdata = {2{r_store_data[15:0]}};
        end else if (r_alucode == ALU_LW || r_alucode == ALU_SW) begin
            mem_be    = 4'b1111;
            mem_wdata = r_store_data;
        end else begin
            mem_be    = 4'b0000;
            mem_wdata = r_store_data;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign mem_req   = (r_state == StAccess);
    assign mem_we    = (r_alucode == ALU_SB) || (r_alucode == ALU_SH) || (r_alucode == ALU_SW);
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign wb_valid  = (r_state == StDone) && w_is_load;
    assign st_done   = (r_state == StDone) && !w_is_load;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    // Reference state: last completed load result.
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucode    (alucode),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .st_done    (st_done),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [5:0] op);
        return (op == ALU_LB || op == ALU_LH || op == ALU_LW || op == ALU_LBU || op == ALU_LHU);
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [31:0] a);
        int sz = op_size(op);
        if (sz == 4) return 4'hF;
        if (sz == 2) return 4'(3 << (a % 4));
        return 4'(1 << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] sd);
        int sz = op_size(op);
        if (sz == 1) return (sd % 256) * 32'h01010101;
        if (sz == 2) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        if (op_size(op) == 1) begin
            v = (rdata >> (8 * (a % 4))) % 256;
            if (op == ALU_LB && v >= 128) v = v + 32'hFFFFFF00;
        end else if (op_size(op) == 2) begin
            v = (rdata >> (16 * ((a / 2) % 2))) % 65536;
            if (op == ALU_LH && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // One operation from the idle state through its completion, checked
    // against the model. Starts and ends #1 after a rising edge.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] r, input logic [31:0] rdata, input int wait_cycles);
        int          sz;
        bit          ld;
        bit          mis;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        sz  = op_size(op);
        ld  = op_load(op);
        mis = (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
        ea  = a - (a % 4);
        eb  = exp_be(op, a);
        ew  = exp_wdata(op, sd);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_accept: got %b want 1", in_ready);
        end
        in_valid = 1'b1; alucode = op; addr = a; store_data = sd; rd = r;
        @(posedge clk); #1;
        in_valid = 1'b0; addr = $urandom; store_data = $urandom; rd = 5'($urandom);
        if (sz == 0 || mis) begin
            checks++;
            if ({mem_req, in_ready, misalign} !== {1'b0, 1'b1, mis}) begin
                failures++;
                $display("FAIL no_access op=%0d: got req/ready/mis=%b%b%b want 01%b",
                         op, mem_req, in_ready, misalign, mis);
            end
            @(posedge clk); #1;
            checks++;
            if ({mem_req, in_ready, misalign} !== 3'b010) begin
                failures++;
                $display("FAIL after_no_access: got req/ready/mis=%b%b%b want 010",
                         mem_req, in_ready, misalign);
            end
            return;
        end
        for (int i = 0; i <= wait_cycles; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if ({mem_req, in_ready, mem_we, wb_valid, st_done} !== {3'b101 ^ {2'b00, ld}, 2'b00}
                || mem_addr !== ea || mem_be !== eb || (!ld && mem_wdata !== ew)) begin
                failures++;
                $display("FAIL access op=%0d a=%h cyc=%0d: got req=%b rdy=%b we=%b addr=%h be=%b wd=%h want req=1 rdy=0 we=%b addr=%h be=%b wd=%h",
                         op, a, i, mem_req, in_ready, mem_we, mem_addr, mem_be, mem_wdata,
                         !ld, ea, eb, ew);
            end
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (ld) begin
            m_wb_rd   = r;
            m_wb_data = exp_load(op, a, rdata);
        end
        checks++;
        if ({wb_valid, st_done, mem_req, in_ready} !== {ld, !ld, 2'b00}
            || wb_rd !== m_wb_rd || wb_data !== m_wb_data) begin
            failures++;
            $display("FAIL strobe op=%0d a=%h: got wbv=%b std=%b req=%b rdy=%b rd=%0d data=%h want wbv=%b std=%b req=0 rdy=0 rd=%0d data=%h",
                     op, a, wb_valid, st_done, mem_req, in_ready, wb_rd, wb_data,
                     ld, !ld, m_wb_rd, m_wb_data);
        end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, st_done, mem_req, in_ready} !== 4'b0001 || wb_data !== m_wb_data
            || wb_rd !== m_wb_rd) begin
            failures++;
            $display("FAIL return_idle: got wbv=%b std=%b req=%b rdy=%b data=%h want 0001 data=%h",
                     wb_valid, st_done, mem_req, in_ready, wb_data, m_wb_data);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; alucode = 6'd0; addr = 32'd0; store_data = 32'd0;
        rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        m_wb_rd = 5'd0; m_wb_data = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_be, wb_valid, st_done, misalign, in_ready} !== 10'b0000000001
            || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            failures++;
            $display("FAIL reset: got req=%b we=%b be=%b addr=%h wd=%h wbv=%b rd=%0d wbd=%h std=%b mis=%b rdy=%b want all 0 rdy=1",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data,
                     st_done, misalign, in_ready);
        end
    endtask

    task automatic test_lw();
        run_op(ALU_LW, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 2);
        checks++;
        if (wb_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_data: got %h want deadbeef", wb_data);
        end
    endtask

    task automatic test_lb_lbu();
        run_op(ALU_LB, 32'h103, 32'h0, 5'd3, 32'h80AA5511, 1);
        checks++;
        if (wb_data !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_data: got %h want ffffff80", wb_data);
        end
        run_op(ALU_LBU, 32'h103, 32'h0, 5'd4, 32'h80AA5511, 0);
        checks++;
        if (wb_data !== 32'h00000080) begin
            failures++;
            $display("FAIL lbu_data: got %h want 00000080", wb_data);
        end
    endtask

    task automatic test_sh();
        run_op(ALU_SH, 32'h206, 32'h1234ABCD, 5'd9, 32'h0, 1);
    endtask

    task automatic test_misalign();
        run_op(ALU_LW, 32'h101, 32'h0, 5'd1, 32'h0, 0);
        run_op(ALU_SH, 32'h003, 32'h5555, 5'd1, 32'h0, 0);
        run_op(6'd3, 32'h40, 32'h0, 5'd1, 32'h0, 0);
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if ({mem_req, wb_valid, st_done, in_ready} !== 4'b0001 || wb_data !== m_wb_data) begin
                failures++;
                $display("FAIL idle_ack: got req=%b wbv=%b std=%b rdy=%b data=%h want 0001 data=%h",
                         mem_req, wb_valid, st_done, in_ready, wb_data, m_wb_data);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_in_access();
        in_valid = 1'b1; alucode = ALU_LW; addr = 32'h300; rd = 5'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_access_req: got %b want 1", mem_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        m_wb_rd = 5'd0; m_wb_data = 32'd0;
        checks++;
        if ({mem_req, mem_be, in_ready, wb_valid, st_done} !== 8'b00000100 || mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL rst_access_drop: got req=%b be=%b rdy=%b wbv=%b std=%b addr=%h want 0 0000 1 0 0 0",
                     mem_req, mem_be, in_ready, wb_valid, st_done, mem_addr);
        end
        repeat (2) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            checks++;
            if ({mem_req, in_ready, wb_valid, st_done} !== 4'b0100 || wb_data !== 32'd0) begin
                failures++;
                $display("FAIL rst_late_ack: got req=%b rdy=%b wbv=%b std=%b data=%h want 0100 data=0",
                         mem_req, in_ready, wb_valid, st_done, wb_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op(ALU_SW, 32'h010, 32'hA5A5_1234, 5'd2, 32'h0, 0);
        run_op(ALU_LHU, 32'h002, 32'h0, 5'd0, 32'hF00D0000, 0);
        checks++;
        if (wb_data !== 32'h0000F00D || wb_rd !== 5'd0) begin
            failures++;
            $display("FAIL lhu_b2b: got rd=%0d data=%h want rd=0 data=0000f00d", wb_rd, wb_data);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [10] = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
                                 ALU_SB, ALU_SH, ALU_SW, 6'd0, 6'd33};
        for (int n = 0; n < 80; n++) begin
            run_op(ops[$urandom_range(9)], $urandom, $urandom, 5'($urandom),
                   $urandom, $urandom_range(3));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_spurious_ack();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
